// File: rtl/fp_div_iter.sv
// Sequential IEEE-754 divider (result = a / b); radix-2 restoring mantissa divide, one quotient bit per cycle.
// Latency: special operands valid after the accepting edge; normal operands MAN_W+5 edges counting the accepting edge.
// Backpressure: in_ready only in IDLE; result/flags held in DONE until out_ready. Define FP_DIV_ROUND_EN for round-to-nearest-even (default truncates).
module fp_div_iter #(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int XLEN  = 1 + EXP_W + MAN_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            overflow,
    output logic            underflow,
    output logic            exception,
    output logic            div_by_zero
);

    localparam int ITER = MAN_W + 3;
    localparam int CW   = $clog2(ITER + 1);
    localparam int EW2  = EXP_W + 2;
    localparam logic [CW-1:0]         CNT_LAST = CW'(ITER - 1);
    localparam logic signed [EW2-1:0] BIAS_S   = EW2'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW2-1:0] E_MAX    = EW2'((1 << EXP_W) - 1);
    localparam logic [XLEN-1:0]       QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;

    state_t state, state_nxt;

    logic                  sign_q;
    logic signed [EW2-1:0] e_q;
    logic [MAN_W+1:0]      rem_q;
    logic [MAN_W:0]        mb_q;
    logic [MAN_W+2:0]      q_q;
    logic [CW-1:0]         cnt_q;

    // operand unpack
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    assign sa = a[XLEN-1];
    assign sb = b[XLEN-1];
    assign ea = a[XLEN-2:MAN_W];
    assign eb = b[XLEN-2:MAN_W];
    assign fa = a[MAN_W-1:0];
    assign fb = b[MAN_W-1:0];

    // special-case classification of incoming operands; exponent 0 counts as zero
    logic             is_special, spec_exc, spec_dbz;
    logic [XLEN-1:0]  spec_res;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, s_in;
    always_comb begin
        a_zero     = (ea == '0);
        b_zero     = (eb == '0);
        a_inf      = (ea == '1) && (fa == '0);
        b_inf      = (eb == '1) && (fb == '0);
        a_nan      = (ea == '1) && (fa != '0);
        b_nan      = (eb == '1) && (fb != '0);
        s_in       = sa ^ sb;
        is_special = 1'b1;
        spec_exc   = 1'b0;
        spec_dbz   = 1'b0;
        spec_res   = '0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res = QNAN;
            spec_exc = 1'b1;
        end else if (b_zero) begin
            spec_res = {s_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            spec_dbz = 1'b1;
        end else if (a_inf) begin
            spec_res = {s_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_inf || a_zero) begin
            spec_res = {s_in, {(XLEN-1){1'b0}}};
        end else begin
            is_special = 1'b0;
        end
    end

    // normalise, round and range-check the finished quotient
    logic [MAN_W+2:0]      qn;
    logic signed [EW2-1:0] en;
    logic [MAN_W+1:0]      mant, mant_r;
    logic [MAN_W-1:0]      frac;
    logic                  round_up;
    logic [XLEN-1:0]       norm_res;
    logic                  norm_ovf, norm_unf;
`ifdef FP_DIV_ROUND_EN
    logic                  guard, sticky;
`endif
    always_comb begin
        qn = q_q;
        en = e_q;
        if (!q_q[MAN_W+2]) begin
            qn = {q_q[MAN_W+1:0], 1'b0};
            en = e_q - EW2'(1);
        end
        mant = {1'b0, qn[MAN_W+2:2]};
`ifdef FP_DIV_ROUND_EN
        guard    = qn[1];
        sticky   = qn[0] | (rem_q != '0);
        round_up = guard & (sticky | qn[2]);
`else
        round_up = 1'b0;
`endif
        mant_r = mant + {{(MAN_W+1){1'b0}}, round_up};
        if (mant_r[MAN_W+1]) begin
            frac = mant_r[MAN_W:1];
            en   = en + EW2'(1);
        end else begin
            frac = mant_r[MAN_W-1:0];
        end
        norm_ovf = 1'b0;
        norm_unf = 1'b0;
        norm_res = {sign_q, en[EXP_W-1:0], frac};
        if (en >= E_MAX) begin
            norm_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            norm_ovf = 1'b1;
        end else if (en <= 0) begin
            norm_res = {sign_q, {(XLEN-1){1'b0}}};
            norm_unf = 1'b1;
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = is_special ? DONE : CALC;
            end
            CALC: if (cnt_q == CNT_LAST) state_nxt = NORM;
            NORM: state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // datapath: operand latch, restoring divide step, result/flag registers
    logic [MAN_W+1:0] rem_sub;
    assign rem_sub = rem_q - {1'b0, mb_q};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q      <= 1'b0;
            e_q         <= '0;
            rem_q       <= '0;
            mb_q        <= '0;
            q_q         <= '0;
            cnt_q       <= '0;
            result      <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            exception   <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sign_q      <= s_in;
                    overflow    <= 1'b0;
                    underflow   <= 1'b0;
                    exception   <= spec_exc;
                    div_by_zero <= spec_dbz;
                    if (is_special) begin
                        result <= spec_res;
                    end else begin
                        rem_q <= {2'b01, fa};
                        mb_q  <= {1'b1, fb};
                        q_q   <= '0;
                        cnt_q <= '0;
                        e_q   <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_S;
                    end
                end
                CALC: begin
                    if (rem_q >= {1'b0, mb_q}) begin
                        rem_q <= {rem_sub[MAN_W:0], 1'b0};
                        q_q   <= {q_q[MAN_W+1:0], 1'b1};
                    end else begin
                        rem_q <= {rem_q[MAN_W:0], 1'b0};
                        q_q   <= {q_q[MAN_W+1:0], 1'b0};
                    end
                    cnt_q <= cnt_q + CW'(1);
                end
                NORM: begin
                    result    <= norm_res;
                    overflow  <= norm_ovf;
                    underflow <= norm_unf;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_iter.sv
// Directed bench for fp_div_iter at single precision: vector table plus hold/reset sequences.
// Latency counted in edges, the accepting edge being edge 1.
// Output backpressure applied by holding out_ready low.
module tb_fp_div_iter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        overflow, underflow, exception, div_by_zero;

    int n_total = 0;
    int n_pass  = 0;

    fp_div_iter #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .overflow(overflow), .underflow(underflow),
        .exception(exception), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flags; // {overflow, underflow, exception, div_by_zero}
        int          lat;
        string       name;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];

`ifdef FP_DIV_ROUND_EN
    localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
    localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [3:0] flags_now();
        return {overflow, underflow, exception, div_by_zero};
    endfunction

    // issue one operation, measure latency, capture result/flags, then drain
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                          output logic [31:0] res, output logic [3:0] fl,
                          output int lat, output int busy_bad);
        int guard_cnt;
        busy_bad  = 0;
        guard_cnt = 0;
        @(negedge clk);
        while (!in_ready && guard_cnt < 100) begin
            @(negedge clk);
            guard_cnt++;
        end
        a = av; b = bv; in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_bad++;
            @(posedge clk);
            lat++;
            #1;
        end
        res = result;
        fl  = flags_now();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("drain_out_valid", {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] r, r_hold;
        logic [3:0]  f, f_hold;
        int          lat, busy, stuck;

        vecs[0]  = '{32'h3F800000, 32'h40000000, 32'h3F000000, 4'b0000, 28, "one_div_two"};
        vecs[1]  = '{32'h40C00000, 32'hBFC00000, 32'hC0800000, 4'b0000, 28, "six_div_m1p5"};
        vecs[2]  = '{32'h3F800000, 32'h40400000, THIRD,        4'b0000, 28, "one_div_three"};
        vecs[3]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0010, 1,  "zero_div_zero"};
        vecs[4]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0001, 1,  "one_div_zero"};
        vecs[5]  = '{32'hBF800000, 32'h7F800000, 32'h80000000, 4'b0000, 1,  "m1_div_inf"};
        vecs[6]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b1000, 28, "overflow"};
        vecs[7]  = '{32'h00800000, 32'h40000000, 32'h00000000, 4'b0100, 28, "underflow"};
        vecs[8]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0010, 1,  "nan_div_one"};
        vecs[9]  = '{32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000, 1,  "inf_div_m2"};
        vecs[10] = '{32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 1,  "subnorm_div_one"};
        vecs[11] = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b0010, 1,  "inf_div_inf"};
        vecs[12] = '{32'h3FC00000, 32'h3F800000, 32'h3FC00000, 4'b0000, 28, "1p5_div_one"};

        // reset state
        #1;
        check("rst_in_ready",  {31'b0, in_ready},  32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result",    result,             32'd0);
        check("rst_flags",     {28'b0, flags_now()}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].a, vecs[i].b, r, f, lat, busy);
            check({vecs[i].name, "_res"},   r,             vecs[i].res);
            check({vecs[i].name, "_flags"}, {28'b0, f},    {28'b0, vecs[i].flags});
            check({vecs[i].name, "_lat"},   32'(lat),      32'(vecs[i].lat));
            check({vecs[i].name, "_busy"},  32'(busy),     32'd0);
        end

        // hold out_ready low for 10 cycles while offering a new operand
        @(negedge clk);
        a = 32'h40C00000; b = 32'hBFC00000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        stuck = 0;
        while (!out_valid && stuck < 100) begin
            @(posedge clk); #1; stuck++;
        end
        r_hold = result; f_hold = flags_now();
        check("hold_first_res", r_hold, 32'hC0800000);
        a = 32'h3F800000; b = 32'h00000000; in_valid = 1'b1;
        busy = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (!out_valid || in_ready || result !== r_hold || flags_now() !== f_hold) busy++;
        end
        in_valid = 1'b0;
        check("hold_stable", 32'(busy), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("hold_release_valid", {31'b0, out_valid}, 32'd0);
        check("hold_release_ready", {31'b0, in_ready},  32'd1);

        // abort with reset during CALC cycle 10
        @(negedge clk);
        a = 32'h3F800000; b = 32'h40400000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        check("abort_in_ready",  {31'b0, in_ready},  32'd1);
        check("abort_result",    result,             32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'h3F800000, 32'h40000000, r, f, lat, busy);
        check("after_abort_res",   r,          32'h3F000000);
        check("after_abort_flags", {28'b0, f}, 32'd0);
        check("after_abort_lat",   32'(lat),   32'd28);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
